// File: rtl/instruction_fetch_responder.sv
// Instruction-fetch / MEM-FIFO bus arbiter.
// Serves single-word and four-word line fetches and MEM-stage FIFO entries
// over one shared bus port with at most one read in flight. Read return data
// is forwarded combinationally to whichever side owns the outstanding read.
module instruction_fetch_responder #(
    parameter int IF_PRIORITY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    // fetch side
    input  logic        i_if_request,
    input  logic [31:0] i_if_address,
    input  logic        i_if_burst,
    output logic [31:0] o_if_data,
    output logic        o_if_valid,
    // MEM FIFO side (show-ahead)
    input  logic        i_fifo_empty,
    input  logic [68:0] i_fifo_q,
    output logic        o_fifo_rdreq,
    output logic [31:0] o_mem_read_data,
    output logic        o_mem_read_valid,
    // bus
    output logic [31:0] o_bus_address,
    output logic        o_bus_read,
    output logic        o_bus_write,
    output logic [3:0]  o_bus_byteenable,
    output logic [31:0] o_bus_writedata,
    input  logic        i_bus_waitrequest,
    input  logic        i_bus_readdatavalid,
    input  logic [31:0] i_bus_readdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IF_CMD,
        ST_IF_WAIT,
        ST_FIFO_CMD,
        ST_FIFO_WAIT
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] if_addr_reg, if_addr_next;
    logic        if_burst_reg, if_burst_next;
    logic [1:0]  word_cnt_reg, word_cnt_next;
    logic        fifo_write_reg, fifo_write_next;
    logic [3:0]  fifo_mask_reg, fifo_mask_next;
    logic [31:0] fifo_addr_reg, fifo_addr_next;
    logic [31:0] fifo_data_reg, fifo_data_next;

    // A pending fetch is taken when it has priority or there is nothing else to do.
    logic fetch_sel;
    assign fetch_sel = i_if_request && ((IF_PRIORITY != 0) || i_fifo_empty);

    // Address bits that alignment discards by construction.
    logic unused_bits;
    assign unused_bits = ^{i_fifo_q[33:32], i_if_address[1:0]};

    // State and latched transaction fields; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            if_addr_reg    <= 32'h0;
            if_burst_reg   <= 1'b0;
            word_cnt_reg   <= 2'd0;
            fifo_write_reg <= 1'b0;
            fifo_mask_reg  <= 4'h0;
            fifo_addr_reg  <= 32'h0;
            fifo_data_reg  <= 32'h0;
        end else begin
            state_reg      <= state_next;
            if_addr_reg    <= if_addr_next;
            if_burst_reg   <= if_burst_next;
            word_cnt_reg   <= word_cnt_next;
            fifo_write_reg <= fifo_write_next;
            fifo_mask_reg  <= fifo_mask_next;
            fifo_addr_reg  <= fifo_addr_next;
            fifo_data_reg  <= fifo_data_next;
        end
    end

    // Next-state and Moore/Mealy outputs; everything idles at zero outside its owning state.
    always_comb begin
        state_next       = state_reg;
        if_addr_next     = if_addr_reg;
        if_burst_next    = if_burst_reg;
        word_cnt_next    = word_cnt_reg;
        fifo_write_next  = fifo_write_reg;
        fifo_mask_next   = fifo_mask_reg;
        fifo_addr_next   = fifo_addr_reg;
        fifo_data_next   = fifo_data_reg;
        o_if_data        = 32'h0;
        o_if_valid       = 1'b0;
        o_fifo_rdreq     = 1'b0;
        o_mem_read_data  = 32'h0;
        o_mem_read_valid = 1'b0;
        o_bus_address    = 32'h0;
        o_bus_read       = 1'b0;
        o_bus_write      = 1'b0;
        o_bus_byteenable = 4'h0;
        o_bus_writedata  = 32'h0;

        case (state_reg)
            ST_IDLE: begin
                if (fetch_sel) begin
                    // Line fills start on the 16-byte boundary and walk upward.
                    if_addr_next  = i_if_burst ? {i_if_address[31:4], 4'h0}
                                               : {i_if_address[31:2], 2'b00};
                    if_burst_next = i_if_burst;
                    word_cnt_next = 2'd0;
                    state_next    = ST_IF_CMD;
                end else if (!i_fifo_empty) begin
                    fifo_write_next = i_fifo_q[68];
                    fifo_mask_next  = i_fifo_q[67:64];
                    fifo_addr_next  = {i_fifo_q[63:34], 2'b00};
                    fifo_data_next  = i_fifo_q[31:0];
                    state_next      = ST_FIFO_CMD;
                end
            end
            ST_IF_CMD: begin
                o_bus_read       = 1'b1;
                o_bus_address    = if_addr_reg + {28'd0, word_cnt_reg, 2'b00};
                o_bus_byteenable = 4'hF;
                if (!i_bus_waitrequest) begin
                    state_next = ST_IF_WAIT;
                end
            end
            ST_IF_WAIT: begin
                if (i_bus_readdatavalid) begin
                    o_if_data  = i_bus_readdata;
                    o_if_valid = 1'b1;
                    if (!if_burst_reg || (word_cnt_reg == 2'd3)) begin
                        state_next = ST_IDLE;
                    end else begin
                        word_cnt_next = word_cnt_reg + 2'd1;
                        state_next    = ST_IF_CMD;
                    end
                end
            end
            ST_FIFO_CMD: begin
                o_bus_address = fifo_addr_reg;
                if (fifo_write_reg) begin
                    o_bus_write      = 1'b1;
                    o_bus_byteenable = fifo_mask_reg;
                    o_bus_writedata  = fifo_data_reg;
                end else begin
                    o_bus_read       = 1'b1;
                    o_bus_byteenable = 4'hF;
                end
                // The head entry is popped only once the bus has taken it.
                if (!i_bus_waitrequest) begin
                    o_fifo_rdreq = 1'b1;
                    state_next   = fifo_write_reg ? ST_IDLE : ST_FIFO_WAIT;
                end
            end
            ST_FIFO_WAIT: begin
                if (i_bus_readdatavalid) begin
                    o_mem_read_data  = i_bus_readdata;
                    o_mem_read_valid = 1'b1;
                    state_next       = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch_responder.sv
// Directed bench for instruction_fetch_responder: table of single transactions
// plus hand-written contention and reset-mid-burst sequences.
module tb_instruction_fetch_responder;

    logic        clk;
    logic        rst_n;

    // inputs / outputs of the IF_PRIORITY=1 instance
    logic        i_if_request, i_if_burst, i_fifo_empty;
    logic [31:0] i_if_address;
    logic [68:0] i_fifo_q;
    logic        i_bus_waitrequest, i_bus_readdatavalid;
    logic [31:0] i_bus_readdata;
    logic [31:0] o_if_data, o_mem_read_data, o_bus_address, o_bus_writedata;
    logic        o_if_valid, o_fifo_rdreq, o_mem_read_valid, o_bus_read, o_bus_write;
    logic [3:0]  o_bus_byteenable;

    // inputs / outputs of the IF_PRIORITY=0 instance
    logic        i_if_request_b, i_if_burst_b, i_fifo_empty_b;
    logic [31:0] i_if_address_b;
    logic [68:0] i_fifo_q_b;
    logic        i_bus_waitrequest_b, i_bus_readdatavalid_b;
    logic [31:0] i_bus_readdata_b;
    logic [31:0] o_if_data_b, o_mem_read_data_b, o_bus_address_b, o_bus_writedata_b;
    logic        o_if_valid_b, o_fifo_rdreq_b, o_mem_read_valid_b, o_bus_read_b, o_bus_write_b;
    logic [3:0]  o_bus_byteenable_b;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 0;

    instruction_fetch_responder #(.IF_PRIORITY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_if_request(i_if_request), .i_if_address(i_if_address), .i_if_burst(i_if_burst),
        .o_if_data(o_if_data), .o_if_valid(o_if_valid),
        .i_fifo_empty(i_fifo_empty), .i_fifo_q(i_fifo_q), .o_fifo_rdreq(o_fifo_rdreq),
        .o_mem_read_data(o_mem_read_data), .o_mem_read_valid(o_mem_read_valid),
        .o_bus_address(o_bus_address), .o_bus_read(o_bus_read), .o_bus_write(o_bus_write),
        .o_bus_byteenable(o_bus_byteenable), .o_bus_writedata(o_bus_writedata),
        .i_bus_waitrequest(i_bus_waitrequest), .i_bus_readdatavalid(i_bus_readdatavalid),
        .i_bus_readdata(i_bus_readdata)
    );

    instruction_fetch_responder #(.IF_PRIORITY(0)) dut_p0 (
        .clk(clk), .rst_n(rst_n),
        .i_if_request(i_if_request_b), .i_if_address(i_if_address_b), .i_if_burst(i_if_burst_b),
        .o_if_data(o_if_data_b), .o_if_valid(o_if_valid_b),
        .i_fifo_empty(i_fifo_empty_b), .i_fifo_q(i_fifo_q_b), .o_fifo_rdreq(o_fifo_rdreq_b),
        .o_mem_read_data(o_mem_read_data_b), .o_mem_read_valid(o_mem_read_valid_b),
        .o_bus_address(o_bus_address_b), .o_bus_read(o_bus_read_b), .o_bus_write(o_bus_write_b),
        .o_bus_byteenable(o_bus_byteenable_b), .o_bus_writedata(o_bus_writedata_b),
        .i_bus_waitrequest(i_bus_waitrequest_b), .i_bus_readdatavalid(i_bus_readdatavalid_b),
        .i_bus_readdata(i_bus_readdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_fifo;
        bit          burst;
        logic [31:0] addr;
        logic [68:0] q;
        int          waits;
        int          lat;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and return the bus responder inputs to idle.
    task automatic step();
        @(negedge clk);
        i_bus_waitrequest     = 1'b0;
        i_bus_readdatavalid   = 1'b0;
        i_bus_readdata        = 32'h0;
        i_bus_waitrequest_b   = 1'b0;
        i_bus_readdatavalid_b = 1'b0;
        i_bus_readdata_b      = 32'h0;
    endtask

    task automatic run_fetch(input vec_t v);
        int nw;
        bit first_seen;
        nw = v.burst ? 4 : 1;
        first_seen = 1'b0;
        step();
        i_if_request = 1'b1;
        i_if_address = v.addr;
        i_if_burst   = v.burst;
        for (int k = 0; k < nw; k++) begin
            for (int c = 0; c <= v.waits; c++) begin
                step();
                if (first_seen) i_if_request = 1'b0;
                i_if_address        = ~v.addr;
                i_bus_waitrequest   = (c < v.waits);
                i_bus_readdatavalid = (c < v.waits);
                i_bus_readdata      = 32'hBAD0_0000;
                #1;
                chk("if_cmd_read", 32'(o_bus_read), 32'd1);
                chk("if_cmd_addr", o_bus_address, v.exp_addr + 32'(4 * k));
                chk("if_cmd_be", 32'(o_bus_byteenable), 32'hF);
                chk("if_cmd_no_strobe", 32'(o_if_valid), 32'd0);
            end
            for (int c = 1; c < v.lat; c++) begin
                step();
                if (first_seen) i_if_request = 1'b0;
                #1;
                chk("if_wait_quiet", 32'({o_if_valid, o_bus_read}), 32'd0);
            end
            step();
            if (first_seen) i_if_request = 1'b0;
            i_bus_readdatavalid = 1'b1;
            i_bus_readdata      = v.rdata + 32'(k);
            #1;
            chk("if_valid", 32'(o_if_valid), 32'd1);
            chk("if_data", o_if_data, v.rdata + 32'(k));
            first_seen = 1'b1;
        end
        for (int c = 0; c < 3; c++) begin
            step();
            i_if_request = 1'b0;
            #1;
            chk("if_done_idle", 32'({o_bus_read, o_bus_write, o_if_valid}), 32'd0);
        end
    endtask

    task automatic run_fifo(input vec_t v);
        bit is_w;
        is_w = v.q[68];
        step();
        i_fifo_empty = 1'b0;
        i_fifo_q     = v.q;
        for (int c = 0; c <= v.waits; c++) begin
            step();
            i_fifo_q            = ~v.q;
            i_bus_waitrequest   = (c < v.waits);
            i_bus_readdatavalid = (c < v.waits);
            #1;
            chk("fifo_cmd_kind", 32'({o_bus_write, o_bus_read}), is_w ? 32'd2 : 32'd1);
            chk("fifo_cmd_addr", o_bus_address, v.exp_addr);
            chk("fifo_cmd_be", 32'(o_bus_byteenable), 32'(v.exp_be));
            if (is_w) chk("fifo_cmd_wdata", o_bus_writedata, v.q[31:0]);
            chk("fifo_rdreq", 32'(o_fifo_rdreq), (c == v.waits) ? 32'd1 : 32'd0);
            chk("fifo_cmd_no_strobe", 32'(o_mem_read_valid), 32'd0);
        end
        if (!is_w) begin
            for (int c = 1; c < v.lat; c++) begin
                step();
                i_fifo_empty = 1'b1;
                #1;
                chk("fifo_wait_quiet", 32'({o_mem_read_valid, o_fifo_rdreq, o_bus_read}), 32'd0);
            end
            step();
            i_fifo_empty        = 1'b1;
            i_bus_readdatavalid = 1'b1;
            i_bus_readdata      = v.rdata;
            #1;
            chk("mem_valid", 32'(o_mem_read_valid), 32'd1);
            chk("mem_data", o_mem_read_data, v.rdata);
            chk("mem_no_if_strobe", 32'(o_if_valid), 32'd0);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            i_fifo_empty = 1'b1;
            #1;
            chk("fifo_done_idle", 32'({o_bus_read, o_bus_write, o_fifo_rdreq, o_mem_read_valid}), 32'd0);
        end
    endtask

    // Bus protocol invariants, sampled mid-low-phase every cycle.
    always begin
        @(negedge clk);
        #2;
        if (mon_en) begin
            chk("rw_exclusive", 32'(o_bus_read & o_bus_write), 32'd0);
            chk("addr_align", 32'(o_bus_address[1:0]), 32'd0);
            chk("rw_exclusive_p0", 32'(o_bus_read_b & o_bus_write_b), 32'd0);
            chk("addr_align_p0", 32'(o_bus_address_b[1:0]), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //         fifo burst addr           q                                            waits lat rdata          exp_addr       be
        vecs[0] = '{1'b0, 1'b0, 32'h0000_1234, 69'h0, 0, 2, 32'hDEAD_BEEF, 32'h0000_1234, 4'hF};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_2038, 69'h0, 0, 1, 32'h1111_0000, 32'h0000_2030, 4'hF};
        vecs[2] = '{1'b0, 1'b1, 32'hFFFF_FFF4, 69'h0, 1, 3, 32'h2222_0000, 32'hFFFF_FFF0, 4'hF};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0ABF, 69'h0, 2, 1, 32'h3333_0000, 32'h0000_0ABC, 4'hF};
        vecs[4] = '{1'b1, 1'b0, 32'h0, {1'b1, 4'b0101, 32'h0000_0100, 32'hAABB_CCDD}, 3, 1, 32'h0, 32'h0000_0100, 4'b0101};
        vecs[5] = '{1'b1, 1'b0, 32'h0, {1'b1, 4'b0000, 32'h0000_0303, 32'h5566_7788}, 0, 1, 32'h0, 32'h0000_0300, 4'b0000};
        vecs[6] = '{1'b1, 1'b0, 32'h0, {1'b0, 4'b0011, 32'h0000_0207, 32'h0}, 1, 2, 32'h1234_5678, 32'h0000_0204, 4'hF};

        rst_n = 1'b0;
        i_if_request = 1'b1; i_if_address = 32'h0000_1234; i_if_burst = 1'b1;
        i_fifo_empty = 1'b0; i_fifo_q = {1'b1, 4'hF, 32'h10, 32'h1};
        i_bus_waitrequest = 1'b0; i_bus_readdatavalid = 1'b1; i_bus_readdata = 32'h5A5A_5A5A;
        i_if_request_b = 1'b0; i_if_address_b = 32'h0; i_if_burst_b = 1'b0;
        i_fifo_empty_b = 1'b1; i_fifo_q_b = 69'h0;
        i_bus_waitrequest_b = 1'b0; i_bus_readdatavalid_b = 1'b0; i_bus_readdata_b = 32'h0;

        // Reset state, with busy inputs applied across a clock edge.
        #13;
        chk("rst_cmd", 32'({o_bus_read, o_bus_write, o_fifo_rdreq}), 32'd0);
        chk("rst_addr", o_bus_address, 32'd0);
        chk("rst_be", 32'(o_bus_byteenable), 32'd0);
        chk("rst_wdata", o_bus_writedata, 32'd0);
        chk("rst_strobes", 32'({o_if_valid, o_mem_read_valid}), 32'd0);
        chk("rst_data", o_if_data | o_mem_read_data, 32'd0);
        step();
        i_if_request = 1'b0; i_fifo_empty = 1'b1;
        step();
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].is_fifo) run_fifo(vecs[i]);
            else run_fetch(vecs[i]);
            $display("vector %0d applied: %s addr=0x%08h", i, vecs[i].is_fifo ? "fifo" : "fetch", vecs[i].exp_addr);
        end

        // Contention, IF_PRIORITY=1: fetch first, FIFO read after one IDLE cycle.
        step();
        i_if_request = 1'b1; i_if_address = 32'h0000_0400; i_if_burst = 1'b0;
        i_fifo_empty = 1'b0; i_fifo_q = {1'b0, 4'h0, 32'h0000_0200, 32'h0};
        step(); #1;
        chk("p1_first_read", 32'(o_bus_read), 32'd1);
        chk("p1_first_addr", o_bus_address, 32'h0000_0400);
        chk("p1_first_no_pop", 32'(o_fifo_rdreq), 32'd0);
        step(); i_bus_readdatavalid = 1'b1; i_bus_readdata = 32'hCAFE_0001; #1;
        chk("p1_if_valid", 32'(o_if_valid), 32'd1);
        chk("p1_if_data", o_if_data, 32'hCAFE_0001);
        step(); i_if_request = 1'b0; #1;
        chk("p1_turnaround_idle", 32'(o_bus_read), 32'd0);
        step(); #1;
        chk("p1_second_addr", o_bus_address, 32'h0000_0200);
        chk("p1_second_pop", 32'({o_bus_read, o_fifo_rdreq}), 32'd3);
        step(); i_fifo_empty = 1'b1; i_bus_readdatavalid = 1'b1; i_bus_readdata = 32'hCAFE_0002; #1;
        chk("p1_mem_valid", 32'(o_mem_read_valid), 32'd1);
        chk("p1_mem_data", o_mem_read_data, 32'hCAFE_0002);
        step(); #1;
        chk("p1_end_idle", 32'({o_bus_read, o_if_valid, o_mem_read_valid}), 32'd0);
        $display("contention IF_PRIORITY=1 applied");

        // Contention, IF_PRIORITY=0: FIFO read first, then the fetch.
        step();
        i_if_request_b = 1'b1; i_if_address_b = 32'h0000_0400; i_if_burst_b = 1'b0;
        i_fifo_empty_b = 1'b0; i_fifo_q_b = {1'b0, 4'h0, 32'h0000_0200, 32'h0};
        step(); #1;
        chk("p0_first_addr", o_bus_address_b, 32'h0000_0200);
        chk("p0_first_pop", 32'({o_bus_read_b, o_fifo_rdreq_b}), 32'd3);
        step(); i_fifo_empty_b = 1'b1; i_bus_readdatavalid_b = 1'b1; i_bus_readdata_b = 32'hBEEF_0001; #1;
        chk("p0_mem_valid", 32'(o_mem_read_valid_b), 32'd1);
        chk("p0_mem_data", o_mem_read_data_b, 32'hBEEF_0001);
        step(); #1;
        chk("p0_turnaround_idle", 32'(o_bus_read_b), 32'd0);
        step(); #1;
        chk("p0_second_read", 32'({o_bus_read_b, o_fifo_rdreq_b}), 32'd2);
        chk("p0_second_addr", o_bus_address_b, 32'h0000_0400);
        step(); i_bus_readdatavalid_b = 1'b1; i_bus_readdata_b = 32'hBEEF_0002; #1;
        chk("p0_if_valid", 32'(o_if_valid_b), 32'd1);
        chk("p0_if_data", o_if_data_b, 32'hBEEF_0002);
        step(); i_if_request_b = 1'b0; #1;
        chk("p0_end_idle", 32'({o_bus_read_b, o_if_valid_b}), 32'd0);
        $display("contention IF_PRIORITY=0 applied");

        // Reset after the second word of a burst.
        step();
        i_if_request = 1'b1; i_if_address = 32'h0000_3000; i_if_burst = 1'b1;
        step(); #1;
        chk("rb_addr0", o_bus_address, 32'h0000_3000);
        step(); i_bus_readdatavalid = 1'b1; i_bus_readdata = 32'h7000_0000; #1;
        chk("rb_valid0", 32'(o_if_valid), 32'd1);
        step(); i_if_request = 1'b0; #1;
        chk("rb_addr1", o_bus_address, 32'h0000_3004);
        step(); i_bus_readdatavalid = 1'b1; i_bus_readdata = 32'h7000_0001; #1;
        chk("rb_valid1", 32'(o_if_valid), 32'd1);
        step(); i_bus_waitrequest = 1'b1; #1;
        chk("rb_addr2_pending", o_bus_address, 32'h0000_3008);
        chk("rb_read_pending", 32'(o_bus_read), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rb_rst_cmd", 32'({o_bus_read, o_bus_write, o_fifo_rdreq, o_if_valid}), 32'd0);
        chk("rb_rst_addr", o_bus_address, 32'd0);
        chk("rb_rst_be", 32'(o_bus_byteenable), 32'd0);
        step();
        rst_n = 1'b1;
        step(); i_bus_readdatavalid = 1'b1; i_bus_readdata = 32'h7000_0002; #1;
        chk("rb_stray_no_if", 32'(o_if_valid), 32'd0);
        chk("rb_stray_no_mem", 32'(o_mem_read_valid), 32'd0);
        chk("rb_stray_idle", 32'(o_bus_read), 32'd0);
        step(); #1;
        chk("rb_end_idle", 32'({o_bus_read, o_if_valid}), 32'd0);
        $display("reset mid-burst applied");

        mon_en = 1'b0;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
